pipelined_rca: RTL and testbench

PIPELINED_RCA -- requirements
Module: pipelined_rca

---
 rtl/pipelined_rca.sv | 122 ++++++++++++
 tb/tb_pipelined_rca.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: CHUNK bits per register stage, operands
// skewed through the pipe, with a global valid/ready stall across all stages.
module pipelined_rca #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (CHUNK >= 1) ? WIDTH / CHUNK : 1;

  if (CHUNK < 1 || (WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0) begin : g_bad_param
    $fatal(1, "pipelined_rca: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // IW: operand bits not yet summed on entry to this stage
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           c_in;
    logic           vld_in;
    logic [CHUNK:0] chunk_res;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    logic           carry_q;
    logic           vld_q;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign vld_in = in_valid;
      assign sum_d  = chunk_res[CHUNK-1:0];
    end else begin : g_next
      assign a_in   = g_stage[k-1].g_rem.a_rem_q;
      assign b_in   = g_stage[k-1].g_rem.b_rem_q;
      assign c_in   = g_stage[k-1].carry_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign sum_d  = {chunk_res[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign chunk_res = add_chunk(a_in[CHUNK-1:0], b_in[CHUNK-1:0], c_in);

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        vld_q   <= vld_in;
        carry_q <= chunk_res[CHUNK];
        sum_q   <= sum_d;
      end
    end

    if (IW > CHUNK) begin : g_rem
      logic [IW-CHUNK-1:0] a_rem_q;
      logic [IW-CHUNK-1:0] b_rem_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (advance) begin
          a_rem_q <= a_in[IW-1:CHUNK];
          b_rem_q <= b_in[IW-1:CHUNK];
        end
      end
    end else begin : g_msb
      // Same-sign operands giving an opposite-sign result is exactly c_in(MSB) ^ c_out(MSB)
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_in[IW-1] == b_in[IW-1]) && (chunk_res[CHUNK-1] != a_in[IW-1]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_msb.ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed arithmetic vectors, stall/reset scenarios,
// narrow configurations, and a scoreboard over a long random handshake run.
module tb_pipelined_rca;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  pipelined_rca #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  logic        v16, rdy16, ov16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  pipelined_rca #(.WIDTH(16), .CHUNK(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .a(a16), .b(b16), .cin(1'b0), .sub(1'b0),
    .out_valid(ov16), .out_ready(1'b1),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  logic        v8, rdy8, ov8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  pipelined_rca #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(ov8), .out_ready(1'b1),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pop    = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}; overflow from the carries into and out of bit 31
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [31:0] ye;
    logic        c_0;
    logic [32:0] full;
    logic [31:0] low;
    ye   = s ? ~y : y;
    c_0  = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, ye} + {32'd0, c_0};
    low  = {1'b0, x[30:0]} + {1'b0, ye[30:0]} + {31'd0, c_0};
    return {low[31] ^ full[32], full[32], full[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("sb_unexpected_result", 64'd1, 64'd0);
        else chk("sb_result", {30'd0, ovf, cout, sum}, {30'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic s, input logic [31:0] es,
                         input logic ec, input logic eo);
    int lat;
    in_valid = 1'b1; out_ready = 1'b1;
    a = av; b = bv; cin = ci; sub = s;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int sent, stalls, pop0, lat;
    logic fire;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0;
    v8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_narrow_ready", {rdy16, rdy8, ov16, ov8}, 4'b1100);
    rst = 1'b0;
    tick();

    run_one("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("add_cin",      32'h0000_000F, 32'h0000_000F, 1'b1, 1'b0, 32'h0000_001F, 1'b0, 1'b0);
    run_one("sub_ignore_cin", 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    tick();

    // Back-to-back stream with downstream stalled for cycles 10..14
    sent = 0; stalls = 0; pop0 = n_pop;
    for (int cyc = 0; cyc < 80 && !(sent == 16 && exp_q.size() == 0); cyc++) begin
      out_ready = !(cyc >= 10 && cyc <= 14);
      in_valid  = (sent < 16);
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      chk("stall_in_ready", in_ready, !(out_valid && !out_ready));
      if (!in_ready) stalls++;
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_results", n_pop - pop0, 16);
    chk("stall_cycles", stalls, 5);

    // Reset with four operand sets in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 32'(i + 10); b = 32'(i); cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", {ovf, cout, sum}, 0);
    tick();
    rst = 1'b0;
    tick();
    run_one("post_reset", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
    tick();

    // Narrow configurations: two-stage and single-stage
    a16 = 16'h00FF; b16 = 16'h0001; v16 = 1'b1;
    a8 = 8'hF0; b8 = 8'h11; v8 = 1'b1;
    tick();
    v16 = 1'b0; v8 = 1'b0;
    chk("w8_latency1_valid", ov8, 1);
    chk("w8_result", {ovf8, cout8, sum8}, {1'b0, 1'b1, 8'h01});
    lat = 1;
    while (!ov16 && lat < 10) begin
      tick();
      lat++;
    end
    chk("w16_latency", lat, 2);
    chk("w16_result", {ovf16, cout16, sum16}, {1'b0, 1'b0, 16'h0100});

    // Long random handshake run against the scoreboard
    pop0 = n_pop;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    chk("random_drain_empty", exp_q.size(), 0);
    chk("random_pops_seen", (n_pop - pop0) > 2000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
